// File: rtl/tile_hash_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tile_hash_scheduler
// Purpose : Round-robin share of one streaming CRC-16 tile hash engine between
//           NUM_REQ requesters. Optional counters: TILE_HASH_SCHED_STATS_EN.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tile_hash_scheduler #(
  parameter  int NUM_REQ    = 2,
  parameter  int TILE_BYTES = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*TILE_BYTES*8-1:0] req_tile_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            eng_data_valid_o,
  output logic [7:0]                      eng_data_in_o,
  output logic                            eng_data_last_o,
  input  logic                            eng_hash_valid_i,
  input  logic [15:0]                     eng_hash_out_i,
  output logic                            rsp_valid_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic [15:0]                     rsp_hash_o,
  input  logic                            rsp_ready_i,
  output logic                            busy_o
`ifdef TILE_HASH_SCHED_STATS_EN
  ,
  output logic [31:0]                     stat_tiles_o,
  output logic [31:0]                     stat_stall_o
`endif
);

  localparam int TILE_W = TILE_BYTES * 8;
  localparam int CNT_W  = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ID_W-1:0]   rr_last_q, rr_last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [15:0]       hash_q, hash_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  int unsigned       cand_i;
  logic              accept;
  logic              last_byte;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_i      = 0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = (int'(rr_last_q) + k) % NUM_REQ;
      cand   = ID_W'(cand_i);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gating with rst_n keeps a requester from believing a tile was taken while reset wins.
  assign accept      = (state_q == S_IDLE) && grant_found && rst_n;
  assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign last_byte   = (byte_cnt_q == CNT_W'(TILE_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    rr_last_d  = rr_last_q;
    id_d       = id_q;
    hash_d     = hash_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) shift_d = req_tile_i[i*TILE_W +: TILE_W];
          end
          id_d       = grant_idx;
          rr_last_d  = grant_idx;
          byte_cnt_d = '0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        shift_d    = shift_q << 8;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (last_byte) begin
          byte_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_hash_valid_i) begin
          hash_d  = eng_hash_out_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      rr_last_q  <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      hash_q     <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      rr_last_q  <= rr_last_d;
      id_q       <= id_d;
      hash_q     <= hash_d;
    end
  end

  assign eng_data_valid_o = (state_q == S_STREAM);
  assign eng_data_in_o    = eng_data_valid_o ? shift_q[TILE_W-1 -: 8] : 8'h00;
  assign eng_data_last_o  = eng_data_valid_o && last_byte;
  assign rsp_valid_o      = (state_q == S_RESP);
  assign rsp_id_o         = id_q;
  assign rsp_hash_o       = hash_q;
  assign busy_o           = (state_q != S_IDLE);

`ifdef TILE_HASH_SCHED_STATS_EN
  logic [31:0] stat_tiles_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_tiles_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (rsp_valid_o && rsp_ready_i)  stat_tiles_q <= stat_tiles_q + 32'd1;
      if (rsp_valid_o && !rsp_ready_i) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_tiles_o = stat_tiles_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_hash_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_tile_hash_scheduler
// Purpose : Directed bench for tile_hash_scheduler with a CRC-16-CCITT engine model.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_tile_hash_scheduler;
  localparam int NR = 2;
  localparam int TB = 16;
  localparam int TW = TB * 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*TW-1:0] req_tile = '0;
  logic            rsp_ready = 1'b1;
  logic            spur_hv = 1'b0;
  logic [15:0]     spur_hash = 16'h0000;

  logic [NR-1:0]   req_ready;
  logic            eng_dv, eng_last, rsp_valid, busy;
  logic [7:0]      eng_din;
  logic [0:0]      rsp_id;
  logic [15:0]     rsp_hash;

  logic [15:0]     eng_crc, eng_hash;
  logic            eng_hv;
  wire             dut_hv   = eng_hv | spur_hv;
  wire [15:0]      dut_hash = spur_hv ? spur_hash : eng_hash;

`ifdef TILE_HASH_SCHED_STATS_EN
  logic [31:0]     stat_tiles, stat_stall;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = -1;
  int exp_tiles = 0;
  int exp_stall = 0;
  logic [15:0] last_hash = 16'h0000;

  tile_hash_scheduler #(.NUM_REQ(NR), .TILE_BYTES(TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_tile_i(req_tile), .req_ready_o(req_ready),
    .eng_data_valid_o(eng_dv), .eng_data_in_o(eng_din), .eng_data_last_o(eng_last),
    .eng_hash_valid_i(dut_hv), .eng_hash_out_i(dut_hash),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_hash_o(rsp_hash),
    .rsp_ready_i(rsp_ready), .busy_o(busy)
`ifdef TILE_HASH_SCHED_STATS_EN
    , .stat_tiles_o(stat_tiles), .stat_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_tile(input logic [TW-1:0] t);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < TB; i++) c = crc_byte(c, t[(TB-1-i)*8 +: 8]);
    return c;
  endfunction

  // Engine: one byte per clock, hash presented the clock after the last byte.
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_crc  <= 16'hFFFF;
      eng_hv   <= 1'b0;
      eng_hash <= 16'h0000;
    end else begin
      eng_hv <= 1'b0;
      if (eng_dv) begin
        if (eng_last) begin
          eng_hash <= crc_byte(eng_crc, eng_din);
          eng_hv   <= 1'b1;
          eng_crc  <= 16'hFFFF;
        end else begin
          eng_crc <= crc_byte(eng_crc, eng_din);
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the IDLE cycle where the grant is expected; ends in the cycle after the response.
  task automatic do_tile(input int id, input logic [TW-1:0] tile, input int stall,
                         input bit drop, input bit gap);
    logic [15:0] h;
    h = crc_tile(tile);
    #1;
    check_val("grant", 32'(req_ready), 32'(1) << id);
    if (gap && last_acc >= 0) check_val("accept_gap", 32'(cyc - last_acc), 32'd19);
    last_acc = cyc;
    tick();
    if (drop) req_valid = '0;
    for (int i = 0; i < TB; i++) begin
      check_val("data_valid", 32'(eng_dv), 32'd1);
      check_val("data_byte", 32'(eng_din), 32'(tile[(TB-1-i)*8 +: 8]));
      check_val("data_last", 32'(eng_last), (i == TB-1) ? 32'd1 : 32'd0);
      check_val("ready_busy", 32'(req_ready), 32'd0);
      tick();
    end
    check_val("wait_dv", 32'(eng_dv), 32'd0);
    check_val("wait_rsp", 32'(rsp_valid), 32'd0);
    if (stall > 0) rsp_ready = 1'b0;
    tick();
    for (int s = 0; s < stall; s++) begin
      check_val("stall_valid", 32'(rsp_valid), 32'd1);
      check_val("stall_id", 32'(rsp_id), 32'(id));
      check_val("stall_hash", 32'(rsp_hash), 32'(h));
      check_val("stall_ready", 32'(req_ready), 32'd0);
      exp_stall++;
      tick();
    end
    rsp_ready = 1'b1;
    check_val("rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("rsp_id", 32'(rsp_id), 32'(id));
    check_val("rsp_hash", 32'(rsp_hash), 32'(h));
    exp_tiles++;
    last_hash = h;
    tick();
  endtask

  task automatic check_stats();
`ifdef TILE_HASH_SCHED_STATS_EN
    check_val("stat_tiles", stat_tiles, 32'(exp_tiles));
    check_val("stat_stall", stat_stall, 32'(exp_stall));
`endif
  endtask

  initial begin
    logic [TW-1:0] t0, t1, t2, t3;
    logic [71:0]   digits;
    logic          seen;
    digits = "123456789";
    t0 = {digits, 56'h0};
    t1 = 128'h000102030405060708090A0B0C0D0E0F;
    t2 = 128'hFFEEDDCCBBAA99887766554433221100;
    t3 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

    // Reset with requests pending: nothing may be granted or driven.
    req_valid = 2'b11;
    repeat (3) tick();
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_dv", 32'(eng_dv), 32'd0);
    check_val("rst_rsp", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_hash", 32'(rsp_hash), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    check_val("idle_busy", 32'(busy), 32'd0);
    check_stats();
    check_val("crc_ref", 32'(crc_byte(crc_byte(crc_byte(crc_byte(crc_byte(crc_byte(
              crc_byte(crc_byte(crc_byte(16'hFFFF, "1"), "2"), "3"), "4"), "5"), "6"),
              "7"), "8"), "9")), 32'h29B1);

    // Single tile from requester 0, valid dropped right after accept.
    req_tile = {t1, t0};
    req_valid = 2'b01;
    do_tile(0, t0, 0, 1'b1, 1'b0);
    check_val("no_regrant", 32'(busy), 32'd0);

    // Fresh reset so round-robin starts from requester 0; both held.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_tiles = 0;
    exp_stall = 0;
    req_tile = {t2, t1};
    req_valid = 2'b11;
    last_acc = -1;
    do_tile(0, t1, 0, 1'b0, 1'b1);
    do_tile(1, t2, 0, 1'b0, 1'b1);
    do_tile(0, t1, 0, 1'b0, 1'b1);
    do_tile(1, t2, 0, 1'b0, 1'b1);
    check_stats();

    // Consumer stalls 10 clocks in RESP.
    req_valid = 2'b01;
    req_tile = {t2, t3};
    do_tile(0, t3, 10, 1'b1, 1'b0);
    check_stats();

    // Reset pulse at byte 7 discards the tile.
    req_valid = 2'b10;
    req_tile = {t3, t2};
    #1;
    check_val("mid_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    repeat (7) tick();
    check_val("byte7", 32'(eng_din), 32'(t3[(TB-1-7)*8 +: 8]));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_tiles = 0;
    exp_stall = 0;
    check_val("mid_ready", 32'(req_ready), 32'd0);
    check_val("mid_dv", 32'(eng_dv), 32'd0);
    check_val("mid_din", 32'(eng_din), 32'd0);
    check_val("mid_last", 32'(eng_last), 32'd0);
    check_val("mid_rsp", 32'(rsp_valid), 32'd0);
    check_val("mid_id", 32'(rsp_id), 32'd0);
    check_val("mid_hash", 32'(rsp_hash), 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    check_stats();
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen = seen | rsp_valid | busy;
      tick();
    end
    check_val("mid_quiet", 32'(seen), 32'd0);
    req_valid = 2'b01;
    req_tile = {t0, t2};
    do_tile(0, t2, 0, 1'b1, 1'b0);
    check_stats();

    // Spurious hash strobe while idle.
    spur_hash = 16'hDEAD;
    spur_hv = 1'b1;
    tick();
    spur_hv = 1'b0;
    check_val("spur_rsp", 32'(rsp_valid), 32'd0);
    check_val("spur_busy", 32'(busy), 32'd0);
    check_val("spur_hash", 32'(rsp_hash), 32'(last_hash));
    tick();
    check_val("spur_rsp2", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
